// File: rtl/rect_fill_engine.sv
// rect_fill_engine
//
// Rasterises one solid axis-aligned rectangle per command into the framebuffer
// write port, one pixel per clock in raster order (x fastest, then y).
//
// Ports:
//   clk, reset          gpu_clk domain clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_x0/y0/x1/y1     rectangle corners (inclusive, any order)
//   cmd_index           palette index to fill with
//   abort               cancels the fill in progress (ignored outside FILL)
//   fb_wr_x/y/index/en  framebuffer write port, registered
//   busy                fill in progress
//   done                one-cycle pulse after the last pixel of a completed fill
//   error               one-cycle pulse when an out-of-range command is rejected
//
// Build option:
//   RECT_FILL_CLIP_EN   when defined, out-of-range corners are clamped to the
//                       framebuffer edge and filled; error is tied low.

module rect_fill_engine #(
    parameter int unsigned RESOLUTION_X   = 400,
    parameter int unsigned RESOLUTION_Y   = 300,
    parameter int unsigned PALETTE_LENGTH = 256,
    localparam int unsigned X_BITS     = $clog2(RESOLUTION_X),
    localparam int unsigned Y_BITS     = $clog2(RESOLUTION_Y),
    localparam int unsigned INDEX_BITS = $clog2(PALETTE_LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_BITS-1:0]     cmd_x0,
    input  logic [Y_BITS-1:0]     cmd_y0,
    input  logic [X_BITS-1:0]     cmd_x1,
    input  logic [Y_BITS-1:0]     cmd_y1,
    input  logic [INDEX_BITS-1:0] cmd_index,
    input  logic                  abort,
    output logic [X_BITS-1:0]     fb_wr_x,
    output logic [Y_BITS-1:0]     fb_wr_y,
    output logic [INDEX_BITS-1:0] fb_wr_index,
    output logic                  fb_wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [X_BITS-1:0] XMax = X_BITS'(RESOLUTION_X - 1);
    localparam logic [Y_BITS-1:0] YMax = Y_BITS'(RESOLUTION_Y - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e                  state_q, state_d;
    logic [X_BITS-1:0]       x_q, x_d;
    logic [Y_BITS-1:0]       y_q, y_d;
    logic [X_BITS-1:0]       xl_q, xl_d;
    logic [X_BITS-1:0]       xh_q, xh_d;
    logic [Y_BITS-1:0]       yh_q, yh_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic                    wr_en_q, wr_en_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;

    // Corners as seen by the capture logic (clamped in the clipping build).
    logic [X_BITS-1:0] cap_x0, cap_x1, cap_xl, cap_xh;
    logic [Y_BITS-1:0] cap_y0, cap_y1, cap_yl, cap_yh;

`ifdef RECT_FILL_CLIP_EN
    always_comb begin
        cap_x0 = (cmd_x0 > XMax) ? XMax : cmd_x0;
        cap_x1 = (cmd_x1 > XMax) ? XMax : cmd_x1;
        cap_y0 = (cmd_y0 > YMax) ? YMax : cmd_y0;
        cap_y1 = (cmd_y1 > YMax) ? YMax : cmd_y1;
    end

    assign error = 1'b0;
`else
    logic cmd_bad;
    logic error_q, error_d;

    always_comb begin
        cap_x0  = cmd_x0;
        cap_x1  = cmd_x1;
        cap_y0  = cmd_y0;
        cap_y1  = cmd_y1;
        cmd_bad = (cmd_x0 > XMax) || (cmd_x1 > XMax) || (cmd_y0 > YMax) || (cmd_y1 > YMax);
    end

    assign error = error_q;
`endif

    // Normalise so the counter always walks low-to-high.
    always_comb begin
        cap_xl = (cap_x0 < cap_x1) ? cap_x0 : cap_x1;
        cap_xh = (cap_x0 < cap_x1) ? cap_x1 : cap_x0;
        cap_yl = (cap_y0 < cap_y1) ? cap_y0 : cap_y1;
        cap_yh = (cap_y0 < cap_y1) ? cap_y1 : cap_y0;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        xl_d    = xl_q;
        xh_d    = xh_q;
        yh_d    = yh_q;
        idx_d   = idx_q;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
`ifndef RECT_FILL_CLIP_EN
        error_d = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (cmd_valid && ready_q) begin
`ifndef RECT_FILL_CLIP_EN
                    // Rejected commands are consumed but leave the engine idle.
                    if (cmd_bad) begin
                        error_d = 1'b1;
                    end else
`endif
                    begin
                        xl_d    = cap_xl;
                        xh_d    = cap_xh;
                        yh_d    = cap_yh;
                        x_d     = cap_xl;
                        y_d     = cap_yl;
                        idx_d   = cmd_index;
                        wr_en_d = 1'b1;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                        state_d = StFill;
                    end
                end
            end

            StFill: begin
                // x_q/y_q is the pixel on the port this cycle; decide the next one.
                if (abort) begin
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else if ((x_q == xh_q) && (y_q == yh_q)) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    wr_en_d = 1'b1;
                    busy_d  = 1'b1;
                    if (x_q == xh_q) begin
                        x_d = xl_q;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end

            StDone: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end

            default: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            xl_q    <= '0;
            xh_q    <= '0;
            yh_q    <= '0;
            idx_q   <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
`ifndef RECT_FILL_CLIP_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xl_q    <= xl_d;
            xh_q    <= xh_d;
            yh_q    <= yh_d;
            idx_q   <= idx_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifndef RECT_FILL_CLIP_EN
            error_q <= error_d;
`endif
        end
    end

    assign cmd_ready   = ready_q;
    assign fb_wr_x     = x_q;
    assign fb_wr_y     = y_q;
    assign fb_wr_index = idx_q;
    assign fb_wr_en    = wr_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: stimulus pushes expected output
// events into a scoreboard queue, a negedge monitor pops and compares them.

module tb_rect_fill_engine;

    localparam int XB = 9;
    localparam int YB = 9;
    localparam int IB = 8;

    localparam int EvWr   = 0;
    localparam int EvDone = 1;
    localparam int EvErr  = 2;

    typedef struct {
        int kind;
        int x;
        int y;
        int idx;
    } ev_t;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [XB-1:0] cmd_x0;
    logic [YB-1:0] cmd_y0;
    logic [XB-1:0] cmd_x1;
    logic [YB-1:0] cmd_y1;
    logic [IB-1:0] cmd_index;
    logic          abort;
    logic [XB-1:0] fb_wr_x;
    logic [YB-1:0] fb_wr_y;
    logic [IB-1:0] fb_wr_index;
    logic          fb_wr_en;
    logic          busy;
    logic          done;
    logic          error;

    int  total = 0;
    int  bad   = 0;
    ev_t sb[$];

    rect_fill_engine dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_x1     (cmd_x1),
        .cmd_y1     (cmd_y1),
        .cmd_index  (cmd_index),
        .abort      (abort),
        .fb_wr_x    (fb_wr_x),
        .fb_wr_y    (fb_wr_y),
        .fb_wr_index(fb_wr_index),
        .fb_wr_en   (fb_wr_en),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int x, input int y, input int idx);
        ev_t e;
        e.kind = EvWr; e.x = x; e.y = y; e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic push_ev(input int kind);
        ev_t e;
        e.kind = kind; e.x = 0; e.y = 0; e.idx = 0;
        sb.push_back(e);
    endtask

    // Raster-order model for the larger rectangles.
    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input int idx);
        int xl = (x0 < x1) ? x0 : x1;
        int xh = (x0 < x1) ? x1 : x0;
        int yl = (y0 < y1) ? y0 : y1;
        int yh = (y0 < y1) ? y1 : y0;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                push_wr(x, y, idx);
        push_ev(EvDone);
    endtask

    // Issue one command; returns at the negedge right after the handshake edge.
    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                            input int idx, input bit exp_fill);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_cmd", int'(cmd_ready), 1);
        cmd_x0    = XB'(x0);
        cmd_y0    = YB'(y0);
        cmd_x1    = XB'(x1);
        cmd_y1    = YB'(y1);
        cmd_index = IB'(idx);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        if (exp_fill) begin
            check("first_wr_next_cycle", int'(fb_wr_en), 1);
            check("busy_in_fill", int'(busy), 1);
            check("ready_low_in_fill", int'(cmd_ready), 0);
        end else begin
            check("error_pulse", int'(error), 1);
            check("no_wr_on_reject", int'(fb_wr_en), 0);
            check("ready_after_reject", int'(cmd_ready), 1);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || !cmd_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    bit prev_done = 1'b0;
    bit prev_wr   = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        int  act;
        if (reset) begin
            prev_done = 1'b0;
            prev_wr   = 1'b0;
        end else begin
            if (prev_done) begin
                check("ready_after_done", int'(cmd_ready), 1);
                check("done_one_cycle", int'(done), 0);
            end
            if (done) check("done_follows_last_wr", int'(prev_wr), 1);
            if (fb_wr_en || done || error) begin
                act = fb_wr_en ? EvWr : (done ? EvDone : EvErr);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got kind=%0d x=%0d y=%0d expected none (t=%0t)",
                             act, fb_wr_x, fb_wr_y, $time);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", act, e.kind);
                    if (act == EvWr && e.kind == EvWr) begin
                        check("wr_x", int'(fb_wr_x), e.x);
                        check("wr_y", int'(fb_wr_y), e.y);
                        check("wr_index", int'(fb_wr_index), e.idx);
                        check("busy_with_wr", int'(busy), 1);
                    end
                end
            end
            prev_done = done;
            prev_wr   = fb_wr_en;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_x1    = '0;
        cmd_y1    = '0;
        cmd_index = '0;
        abort     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(cmd_ready), 0);
        check("rst_wr_en", int'(fb_wr_en), 0);
        check("rst_x", int'(fb_wr_x), 0);
        check("rst_y", int'(fb_wr_y), 0);
        check("rst_idx", int'(fb_wr_index), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("ready_low_before_edge", int'(cmd_ready), 0);
        @(negedge clk);
        check("ready_one_cycle_after_release", int'(cmd_ready), 1);

        // (2,3)-(4,4) idx 0x5A, hand-computed order
        push_wr(2, 3, 'h5A); push_wr(3, 3, 'h5A); push_wr(4, 3, 'h5A);
        push_wr(2, 4, 'h5A); push_wr(3, 4, 'h5A); push_wr(4, 4, 'h5A);
        push_ev(EvDone);
        send_cmd(2, 3, 4, 4, 'h5A, 1'b1);
        wait_idle(50);

        // Swapped corners give the identical sequence
        push_wr(2, 3, 'h5A); push_wr(3, 3, 'h5A); push_wr(4, 3, 'h5A);
        push_wr(2, 4, 'h5A); push_wr(3, 4, 'h5A); push_wr(4, 4, 'h5A);
        push_ev(EvDone);
        send_cmd(4, 4, 2, 3, 'h5A, 1'b1);
        wait_idle(50);

        // 1x1 at the far corner
        push_wr(399, 299, 'hFF);
        push_ev(EvDone);
        send_cmd(399, 299, 399, 299, 'hFF, 1'b1);
        wait_idle(50);

        // Full-width band ending on (399,299)
        push_rect(0, 200, 399, 299, 'hC3);
        send_cmd(0, 200, 399, 299, 'hC3, 1'b1);
        wait_idle(40_100);

        // Abort on the 3rd write
        push_wr(0, 0, 'h33); push_wr(1, 0, 'h33); push_wr(2, 0, 'h33);
        send_cmd(0, 0, 9, 0, 'h33, 1'b1);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_wr_stops", int'(fb_wr_en), 0);
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_no_done", int'(done), 0);
        check("abort_holds_x", int'(fb_wr_x), 2);
        wait_idle(50);

        // Next command after abort, with abort held high while idle (ignored)
        abort = 1'b1;
        push_wr(7, 8, 'h42); push_wr(8, 8, 'h42);
        push_ev(EvDone);
        send_cmd(7, 8, 8, 8, 'h42, 1'b1);
        wait_idle(50);

        // Out-of-range x1
`ifdef RECT_FILL_CLIP_EN
        push_wr(398, 0, 'h77); push_wr(399, 0, 'h77);
        push_wr(398, 1, 'h77); push_wr(399, 1, 'h77);
        push_ev(EvDone);
        send_cmd(398, 0, 400, 1, 'h77, 1'b1);
`else
        push_ev(EvErr);
        send_cmd(398, 0, 400, 1, 'h77, 1'b0);
`endif
        wait_idle(50);
        @(negedge clk);
        check("error_single_pulse", int'(error), 0);

        // Reset in the middle of (0,0)-(9,9)
        push_rect(0, 0, 9, 9, 'h21);
        send_cmd(0, 0, 9, 9, 'h21, 1'b1);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_wr_en", int'(fb_wr_en), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(cmd_ready), 0);
        check("midrst_done", int'(done), 0);
        sb.delete();
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_midrst", int'(cmd_ready), 1);
        repeat (5) @(negedge clk);
        check("no_residual_wr", int'(fb_wr_en), 0);

        // Engine still works after the reset
        push_wr(1, 1, 'h0C); push_wr(2, 1, 'h0C);
        push_wr(1, 2, 'h0C); push_wr(2, 2, 'h0C);
        push_ev(EvDone);
        send_cmd(2, 2, 1, 1, 'h0C, 1'b1);
        wait_idle(50);

        repeat (3) @(negedge clk);
        check("final_scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Rasterises solid axis-aligned rectangles into the framebuffer write port, one pixel per clock.
- Sits directly upstream of the framebuffer write side, in the gpu_clk domain, and is fed by the display processor's command path.
- Takes one rectangle command over a valid/ready handshake and emits fb_wr_x/fb_wr_y/fb_wr_index/fb_wr_en in raster order.
- Reports busy and completion back to the command source.

Parameters:
RESOLUTION_X, 400, framebuffer width in pixels; X_BITS = $clog2(RESOLUTION_X)
RESOLUTION_Y, 300, framebuffer height in pixels; Y_BITS = $clog2(RESOLUTION_Y)
PALETTE_LENGTH, 256, palette entries; INDEX_BITS = $clog2(PALETTE_LENGTH)

Ports:
clk  in  1  gpu_clk domain clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command
cmd_x0  in  X_BITS  first corner x
cmd_y0  in  Y_BITS  first corner y
cmd_x1  in  X_BITS  opposite corner x (inclusive)
cmd_y1  in  Y_BITS  opposite corner y (inclusive)
cmd_index  in  INDEX_BITS  palette index to fill with
abort  in  1  synchronous cancel of the fill in progress
fb_wr_x  out  X_BITS  write pixel x
fb_wr_y  out  Y_BITS  write pixel y
fb_wr_index  out  INDEX_BITS  write palette index
fb_wr_en  out  1  write strobe, one pixel per asserted cycle
busy  out  1  fill in progress
done  out  1  one-cycle pulse after the last pixel of a completed fill
error  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (asynchronous, active-high): state IDLE. cmd_ready=1 one cycle after release (0 while reset is held). fb_wr_en=0, fb_wr_x=0, fb_wr_y=0, fb_wr_index=0, busy=0, done=0, error=0.
- Reset asserted mid-fill: all outputs return to reset values immediately, with no further writes.
- States: IDLE, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready the command is captured and normalised: xl=min(x0,x1), xh=max(x0,x1), yl=min(y0,y1), yh=max(y0,y1).
  - Next state is FILL, with the pixel counter at (xl,yl).
- FILL:
  - cmd_ready=0, busy=1, fb_wr_en=1 every cycle.
  - Outputs are registered: first write appears the cycle after acceptance.
  - Order: x increments each cycle. At x==xh, x wraps to xl and y increments.
  - Pixel (xh,yh) is the last write, then the state goes to DONE.
  - Pixel count = (xh-xl+1)*(yh-yl+1); a 1x1 rectangle is exactly one write.
- DONE:
  - One cycle with done=1, fb_wr_en=0, busy=0, cmd_ready=0.
  - Then IDLE.
  - Minimum spacing between commands is therefore pixels+2 cycles.
- abort:
  - Sampled only in FILL. The cycle after abort is seen, fb_wr_en=0 and state is IDLE.
  - No done pulse. Writes already issued remain.
  - abort in IDLE or DONE is ignored.
- Range check (macro off): if any of x0, x1 >= RESOLUTION_X or y0, y1 >= RESOLUTION_Y, the command is accepted but not executed. error pulses the next cycle, zero writes occur, and the state stays IDLE.
- fb_wr_x/y/index hold their last value when fb_wr_en=0.
- Arithmetic is unsigned at port widths. The counter never exceeds xh/yh, so there is no overflow.

Optional Feature:
RECT_FILL_CLIP_EN
- Defined: out-of-range coordinates are clamped to RESOLUTION_X-1 / RESOLUTION_Y-1 at capture. The clamped rectangle is filled, done pulses normally, and error is never asserted (tied 0).
- Undefined: the reject-with-error behaviour above applies.

Test Plan:
- Reset release, then command (2,3)-(4,4) idx 0x5A -> 6 writes in order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), index 0x5A; first write one cycle after handshake; done pulses the cycle after (4,4); cmd_ready high the cycle after done.
- Swapped corners (4,4)-(2,3) -> identical write sequence to the previous case.
- 1x1 at (399,299) idx 0xFF -> exactly one write at (399,299); full corners (0,0)-(399,299) -> 120000 writes, final (399,299).
- abort asserted on the 3rd write of (0,0)-(9,0) -> writes (0,0),(1,0),(2,0) only; no done; cmd_ready=1 next cycle; next command executes normally.
- Command x1=400: macro off -> error pulse, zero writes, done=0; macro on -> x clamped to 399, fill completes with done.
- reset asserted mid-fill of (0,0)-(9,9) -> fb_wr_en=0 and busy=0 immediately; after release the engine is in IDLE with cmd_ready=1 and no residual writes.
